// File: rtl/calc_pkg.sv
// Shared calculator display constants: BCD blank/error codes, converter state
// encoding and the per-digit double-dabble correction function.
package calc_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hA;
    localparam logic [3:0] BCD_ERR   = 4'hF;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] SHIFT_ENC = 2'd1;
    localparam logic [1:0] ERR_ENC   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE_ENC,
        S_SHIFT = SHIFT_ENC,
        S_ERR   = ERR_ENC
    } conv_state_e;

    function automatic logic [3:0] add3_fn(input logic [3:0] digit);
        logic [3:0] res;
        if (digit >= 4'd5) begin
            res = digit + 4'd3;
        end else begin
            res = digit;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble correction for one BCD digit (>=5 gets +3).
module bcd_add3
    import calc_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Per-digit correction applied before every shift.
    always_comb begin
        dout = add3_fn(din);
    end

endmodule

// File: rtl/result_bcd_converter.sv
// Signed binary result to packed BCD converter, one bit per clock.
// Optional macro LEADING_ZERO_BLANK_EN replaces leading zero digits with the blank code.
module result_bcd_converter
    import calc_pkg::*;
#(
    parameter int WIDTH  = 28,
    parameter int DIGITS = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      d_in,
    input  logic                  valid_in,
    input  logic                  ovrflow_in,
    output logic                  busy,
    output logic                  valid_out,
    output logic                  sign_out,
    output logic                  err_out,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);

    conv_state_e          state_q, state_d;
    logic [WIDTH-1:0]     mag_q, mag_d;
    logic [BW-1:0]        work_q, work_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sign_lat_q, sign_lat_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 sign_q, sign_d;
    logic                 err_q, err_d;
    logic [BW-1:0]        bcd_q, bcd_d;

    logic [BW-1:0]        adj_s;
    logic [BW+WIDTH-1:0]  shifted_s;
    logic [BW-1:0]        disp_s;
    logic [WIDTH-1:0]     abs_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (work_q[4*g +: 4]),
            .dout (adj_s[4*g +: 4])
        );
    end

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        if (d_in[WIDTH-1]) begin
            abs_s = ~d_in + WIDTH'(1);
        end else begin
            abs_s = d_in;
        end
    end

    // Corrected digits and magnitude shift left together as one long register.
    always_comb begin
        shifted_s = {adj_s, mag_q} << 1'b1;
    end

    // Display formatting of the digits produced by the final shift.
    always_comb begin : blank_blk
        logic lead;
        disp_s = shifted_s[BW+WIDTH-1:WIDTH];
        lead   = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (disp_s[4*i +: 4] == 4'h0)) begin
                disp_s[4*i +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
`else
        lead = 1'b0;
`endif
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        sign_lat_d = sign_lat_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        sign_d     = sign_q;
        err_d      = err_q;
        bcd_d      = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    busy_d = 1'b1;
                    if (ovrflow_in) begin
                        state_d = S_ERR;
                    end else begin
                        mag_d      = abs_s;
                        sign_lat_d = d_in[WIDTH-1];
                        work_d     = '0;
                        cnt_d      = CW'(WIDTH - 1);
                        state_d    = S_SHIFT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_d = shifted_s[BW+WIDTH-1:WIDTH];
                mag_d  = shifted_s[WIDTH-1:0];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    bcd_d   = disp_s;
                    sign_d  = sign_lat_q;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ERR: begin
                bcd_d   = {DIGITS{BCD_ERR}};
                err_d   = 1'b1;
                sign_d  = 1'b0;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any conversion in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mag_q      <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            sign_lat_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            sign_q     <= 1'b0;
            err_q      <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            sign_lat_q <= sign_lat_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            sign_q     <= sign_d;
            err_q      <= err_d;
            bcd_q      <= bcd_d;
        end
    end

    assign busy      = busy_q;
    assign valid_out = valid_q;
    assign sign_out  = sign_q;
    assign err_out   = err_q;
    assign bcd_out   = bcd_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed self-checking bench for result_bcd_converter (both LEADING_ZERO_BLANK_EN builds).
module tb_result_bcd_converter;

    logic        clk;
    logic        rst;
    logic [27:0] d_in;
    logic        valid_in;
    logic        ovrflow_in;
    logic        busy;
    logic        valid_out;
    logic        sign_out;
    logic        err_out;
    logic [35:0] bcd_out;

    int n_cmp;
    int n_bad;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [35:0] EXP_FACT = 36'hA39916800;
    localparam logic [35:0] EXP_5    = 36'hAAAAAAAA5;
    localparam logic [35:0] EXP_0    = 36'hAAAAAAAA0;
    localparam logic [35:0] EXP_123  = 36'hAAAAAA123;
    localparam logic [35:0] EXP_42   = 36'hAAAAAAA42;
    localparam logic [35:0] EXP_1000 = 36'hAAAAA1000;
`else
    localparam logic [35:0] EXP_FACT = 36'h039916800;
    localparam logic [35:0] EXP_5    = 36'h000000005;
    localparam logic [35:0] EXP_0    = 36'h000000000;
    localparam logic [35:0] EXP_123  = 36'h000000123;
    localparam logic [35:0] EXP_42   = 36'h000000042;
    localparam logic [35:0] EXP_1000 = 36'h000001000;
`endif

    result_bcd_converter #(.WIDTH(28), .DIGITS(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .valid_in   (valid_in),
        .ovrflow_in (ovrflow_in),
        .busy       (busy),
        .valid_out  (valid_out),
        .sign_out   (sign_out),
        .err_out    (err_out),
        .bcd_out    (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: present one request for exactly one rising edge.
    task automatic start_conv(input logic [27:0] v, input logic ovf);
        d_in       = v;
        ovrflow_in = ovf;
        valid_in   = 1'b1;
        @(negedge clk);
        valid_in   = 1'b0;
        ovrflow_in = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; d_in = '0; valid_in = 1'b0; ovrflow_in = 1'b0;
        #12;
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (bcd_out !== 36'h0) begin n_bad++; $display("FAIL reset_bcd: got %h want 0", bcd_out); end
        n_cmp++; if ({sign_out, err_out} !== 2'b00) begin n_bad++; $display("FAIL reset_sign_err: got %b want 00", {sign_out, err_out}); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_factorial();
        int lat;
        start_conv(28'd39916800, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fact_busy: got %b want 1", busy); end
        wait_valid(lat);
        n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL fact_latency: got %0d want 28", lat); end
        n_cmp++; if (bcd_out !== EXP_FACT) begin n_bad++; $display("FAIL fact_bcd: got %h want %h", bcd_out, EXP_FACT); end
        n_cmp++; if ({sign_out, err_out, busy} !== 3'b000) begin n_bad++; $display("FAIL fact_flags: got %b want 000", {sign_out, err_out, busy}); end
        @(negedge clk);
        n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL fact_pulse_width: got %b want 0", valid_out); end
        n_cmp++; if (bcd_out !== EXP_FACT) begin n_bad++; $display("FAIL fact_hold: got %h want %h", bcd_out, EXP_FACT); end
    endtask

    task automatic test_signed_values();
        int lat;
        start_conv(28'hFFFFFFB, 1'b0);
        wait_valid(lat);
        n_cmp++; if (bcd_out !== EXP_5) begin n_bad++; $display("FAIL neg5_bcd: got %h want %h", bcd_out, EXP_5); end
        n_cmp++; if (sign_out !== 1'b1) begin n_bad++; $display("FAIL neg5_sign: got %b want 1", sign_out); end
        start_conv(28'h8000000, 1'b0);
        wait_valid(lat);
        n_cmp++; if (bcd_out !== 36'h134217728) begin n_bad++; $display("FAIL min_bcd: got %h want 134217728", bcd_out); end
        n_cmp++; if (sign_out !== 1'b1) begin n_bad++; $display("FAIL min_sign: got %b want 1", sign_out); end
        start_conv(28'h7FFFFFF, 1'b0);
        wait_valid(lat);
        n_cmp++; if (bcd_out !== 36'h134217727) begin n_bad++; $display("FAIL max_bcd: got %h want 134217727", bcd_out); end
        n_cmp++; if (sign_out !== 1'b0) begin n_bad++; $display("FAIL max_sign: got %b want 0", sign_out); end
        start_conv(28'hFFFFC18, 1'b0);
        wait_valid(lat);
        n_cmp++; if ({sign_out, bcd_out} !== {1'b1, EXP_1000}) begin n_bad++; $display("FAIL neg1000: got %b %h want 1 %h", sign_out, bcd_out, EXP_1000); end
        start_conv(28'd0, 1'b0);
        wait_valid(lat);
        n_cmp++; if ({sign_out, bcd_out} !== {1'b0, EXP_0}) begin n_bad++; $display("FAIL zero: got %b %h want 0 %h", sign_out, bcd_out, EXP_0); end
    endtask

    task automatic test_overflow();
        int lat;
        start_conv(28'hFFFFFFB, 1'b0);
        wait_valid(lat);
        d_in = 28'd12; ovrflow_in = 1'b1; valid_in = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL err_busy: got %b want 1", busy); end
        @(negedge clk);
        valid_in = 1'b0; ovrflow_in = 1'b0;
        n_cmp++; if (valid_out !== 1'b1) begin n_bad++; $display("FAIL err_latency: got valid %b want 1", valid_out); end
        n_cmp++; if (bcd_out !== 36'hFFFFFFFFF) begin n_bad++; $display("FAIL err_bcd: got %h want FFFFFFFFF", bcd_out); end
        n_cmp++; if ({sign_out, err_out, busy} !== 3'b010) begin n_bad++; $display("FAIL err_flags: got %b want 010", {sign_out, err_out, busy}); end
        @(negedge clk);
        n_cmp++; if ({valid_out, busy} !== 2'b00) begin n_bad++; $display("FAIL err_ignored_in_err: got %b want 00", {valid_out, busy}); end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_conv(28'd123, 1'b0);
        wait_valid(lat);
        start_conv(28'd42, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
        wait_valid(lat);
        n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL b2b_latency: got %0d want 28", lat); end
        n_cmp++; if ({err_out, bcd_out} !== {1'b0, EXP_42}) begin n_bad++; $display("FAIL b2b_bcd: got %b %h want 0 %h", err_out, bcd_out, EXP_42); end
    endtask

    task automatic test_ignore_busy();
        int pulses;
        int lat;
        logic [35:0] cap;
        pulses = 0; lat = -1; cap = '0;
        start_conv(28'd123, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin d_in = 28'd7; valid_in = 1'b1; end
            if (i == 8) valid_in = 1'b0;
            @(negedge clk);
            if (valid_out === 1'b1) begin
                pulses++;
                lat = i;
                cap = bcd_out;
            end
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
        n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL ignore_latency: got %0d want 28", lat); end
        n_cmp++; if (cap !== EXP_123) begin n_bad++; $display("FAIL ignore_bcd: got %h want %h", cap, EXP_123); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int lat;
        pulses = 0;
        start_conv(28'd999, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({valid_out, busy, sign_out, err_out} !== 4'b0000) begin n_bad++; $display("FAIL midrst_flags: got %b want 0000", {valid_out, busy, sign_out, err_out}); end
        n_cmp++; if (bcd_out !== 36'h0) begin n_bad++; $display("FAIL midrst_bcd: got %h want 0", bcd_out); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            @(negedge clk);
            if (valid_out === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_no_valid: got %0d pulses want 0", pulses); end
        start_conv(28'd42, 1'b0);
        wait_valid(lat);
        n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL midrst_latency: got %0d want 28", lat); end
        n_cmp++; if (bcd_out !== EXP_42) begin n_bad++; $display("FAIL midrst_bcd42: got %h want %h", bcd_out, EXP_42); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_factorial();
        test_signed_values();
        test_overflow();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
